// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB initiator.
//   apb_state_e   - initiator FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   APB_ADDR_W    - default PADDR/req_addr width
//   APB_DATA_W    - default data width
//   APB_TIMEOUT   - default ACCESS-phase abort limit (used with APB_INIT_TIMEOUT_EN)
package apb_pkg;

    localparam int APB_ADDR_W  = 13;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB initiator. Turns a valid/ready request
// into one APB SETUP/ACCESS transfer and returns a valid/ready response.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   req_valid/req_ready               request handshake (accepted only in IDLE)
//   req_write, req_addr, req_wdata    request fields, latched on accept
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata, rsp_err                read data (0 on writes/errors), error flag
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request signals
//   PRDATA, PREADY, PSLVERR                APB completer signals
//
// Build option
//   APB_INIT_TIMEOUT_EN - abort an ACCESS phase that waits TIMEOUT PREADY=0
//                         cycles; the response then carries rsp_err=1.
//
// state  | meaning
// IDLE   | ready for a request, APB bus idle
// SETUP  | PSEL=1, PENABLE=0 for one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY (or timeout)
// RESP   | response held until rsp_ready
module apb_initiator
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e        state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

`ifdef APB_INIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc = cnt_q + 1'b1;
`endif

    // Bus strobes decode straight from the state register so that an
    // asynchronous reset drops them immediately.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef APB_INIT_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
`ifdef APB_INIT_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    // Error responses never carry read data.
                    rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = ST_RESP;
                end
`ifdef APB_INIT_TIMEOUT_EN
                // cnt_inc counts this cycle too, so the abort lands on the
                // TIMEOUT-th stalled ACCESS cycle.
                else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef APB_INIT_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef APB_INIT_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_initiator.sv
module tb_apb_initiator;

`ifdef APB_INIT_TIMEOUT_EN
    localparam int TO = 8;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [12:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_initiator #(
        .ADDR_W (13),
        .DATA_W (32)
`ifdef APB_INIT_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] wdata;
        int          waits;     // PREADY=0 ACCESS cycles before completion
        logic [31:0] prdata;
        logic        slverr;
        int          rdly;      // cycles rsp_ready is held low
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the response must carry for a given completer behaviour.
    function automatic void model(inout vec_t v);
        bit timed_out = 1'b0;
`ifdef APB_INIT_TIMEOUT_EN
        timed_out = (v.waits >= TO);
`endif
        if (timed_out)         begin v.exp_rdata = 0; v.exp_err = 1'b1; end
        else if (v.slverr)     begin v.exp_rdata = 0; v.exp_err = 1'b1; end
        else if (v.wr)         begin v.exp_rdata = 0; v.exp_err = 1'b0; end
        else                   begin v.exp_rdata = v.prdata; v.exp_err = 1'b0; end
    endfunction

    task automatic junk_req();
        req_write = 1'($urandom);
        req_addr  = 13'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic xfer(input vec_t v);
        int n_acc;
        n_acc = v.waits + 1;
`ifdef APB_INIT_TIMEOUT_EN
        if (v.waits >= TO) n_acc = TO;
`endif
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1;
        // Keep offering garbage while busy: it must be ignored.
        junk_req();
        @(negedge clk);
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwrite", PWRITE, v.wr);
        chk("setup_pwdata", PWDATA, v.wdata);
        chk("setup_req_ready", req_ready, 0);
        for (int i = 0; i < n_acc; i++) begin
            @(negedge clk);
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, v.addr);
            chk("access_pwdata", PWDATA, v.wdata);
            chk("access_rsp_valid", rsp_valid, 0);
            PREADY  = (i == v.waits);
            PRDATA  = (i == v.waits) ? v.prdata : $urandom;
            PSLVERR = (i == v.waits) ? v.slverr : 1'($urandom);
            @(posedge clk);
            #1;
            PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
        for (int d = 0; d <= v.rdly; d++) begin
            @(negedge clk);
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("rsp_err", rsp_err, v.exp_err);
            chk("resp_psel", PSEL, 0);
            chk("resp_penable", PENABLE, 0);
            chk("resp_req_ready", req_ready, 0);
            rsp_ready = (d == v.rdly);
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            req_valid = 1'b0;
        end
        @(negedge clk);
        chk("after_rsp_valid", rsp_valid, 0);
        chk("after_req_ready", req_ready, 1);
        chk("hold_paddr", PADDR, v.addr);
        chk("hold_pwrite", PWRITE, v.wr);
    endtask

    initial begin
        vec_t v;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        reset_n = 1'b1;

        //          wr   addr      wdata         waits prdata        slv  rdly exp_rdata     exp_err
        tbl.push_back('{1'b1, 13'h0,    32'h0000_00ab, 0, 32'h1111_1111, 1'b0, 0, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 13'h4,    32'h0,         2, 32'h0000_0003, 1'b0, 0, 32'h3,         1'b0});
        tbl.push_back('{1'b1, 13'h10,   32'h0000_0055, 1, 32'h2222_2222, 1'b1, 0, 32'h0,         1'b1});
        tbl.push_back('{1'b0, 13'h8,    32'h0,         0, 32'hdead_beef, 1'b0, 0, 32'hdead_beef, 1'b0});
        tbl.push_back('{1'b0, 13'h1fff, 32'h0,         0, 32'hcafe_f00d, 1'b0, 5, 32'hcafe_f00d, 1'b0});
        tbl.push_back('{1'b0, 13'hc,    32'h0,         3, 32'h1234_5678, 1'b1, 1, 32'h0,         1'b1});
`ifdef APB_INIT_TIMEOUT_EN
        tbl.push_back('{1'b0, 13'h20,   32'h0,        20, 32'h7777_7777, 1'b0, 0, 32'h0,         1'b1});
        tbl.push_back('{1'b0, 13'h24,   32'h0,         7, 32'h0000_0077, 1'b0, 0, 32'h77,        1'b0});
        tbl.push_back('{1'b1, 13'h28,   32'h5,         6, 32'h0,         1'b0, 0, 32'h0,         1'b0});
`endif
        for (int i = 0; i < tbl.size(); i++) xfer(tbl[i]);

        // Reset asserted mid-ACCESS: strobes must drop before the next edge.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_penable", PENABLE, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_psel", PSEL, 0);
        chk("async_rst_penable", PENABLE, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        v = '{1'b0, 13'h4, 32'h0, 1, 32'h0000_0009, 1'b0, 0, 32'h0, 1'b0};
        model(v);
        xfer(v);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            v.wr     = 1'($urandom);
            v.addr   = 13'($urandom);
            v.wdata  = $urandom;
            v.waits  = $urandom_range(0, 3);
            v.prdata = $urandom;
            v.slverr = ($urandom_range(0, 3) == 0);
            v.rdly   = $urandom_range(0, 2);
            model(v);
            xfer(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
